lfsr_led_sequencer: RTL and testbench



---
 rtl/lfsr_pkg.sv | 9 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/lfsr_led_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_lfsr_led_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR LED sequencer.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] SAFE_SEED_DEF = 16'h0001;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StPause} state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter; emits a one-clk pulse on an accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    // Any sample matching the accepted level restarts the stability count.
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/lfsr_led_sequencer.sv
// Control FSM sequencing load/shift commands to an external 16-bit LFSR and mirroring it on LEDs.
module lfsr_led_sequencer
  import lfsr_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = 65536,
  parameter int unsigned       RATE_DIV        = 1,
  parameter logic [LFSR_W-1:0] SAFE_SEED       = SAFE_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_load,
  input  logic [LFSR_W-1:0] seed_sw,
  input  logic [LFSR_W-1:0] lfsr_q,
  output logic              lfsr_load,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              lfsr_shift,
  output logic [LFSR_W-1:0] led,
  output logic              running,
  output logic              lockup
);

  localparam int unsigned CntW = $clog2(RATE_DIV) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RATE_DIV - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LFSR_W-1:0] led_q, led_d, seed_q, seed_d;
  logic run_after_q, run_after_d, tick_pend_q, tick_pend_d;
  logic pend_load_q, pend_load_d, pend_run_q, pend_run_d, pend_step_q, pend_step_d;
  logic cap_pend_q, cap_pend_d, force_q, force_d;
  logic load_q, load_d, shift_q, shift_d, running_q, running_d, lockup_q, lockup_d;
  logic press_load, press_run, press_step;
  logic ev_load, ev_run, ev_step, ev_tick, busy, go_load, go_run_after;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_load), .press_o(press_load)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_run), .press_o(press_run)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_step), .press_o(press_step)
  );

  // Events are held while a command or capture is in flight, then resolved by priority.
  assign ev_load = press_load | pend_load_q;
  assign ev_run  = press_run | pend_run_q;
  assign ev_step = press_step | pend_step_q;
  assign ev_tick = tick | tick_pend_q;
  assign busy    = load_q | shift_q | cap_pend_q;

  always_comb begin
    state_d      = state_q;
    run_after_d  = run_after_q;
    cnt_d        = cnt_q;
    tick_pend_d  = ev_tick;
    pend_load_d  = ev_load;
    pend_run_d   = ev_run;
    pend_step_d  = ev_step;
    cap_pend_d   = load_q | shift_q;
    force_d      = force_q;
    led_d        = led_q;
    seed_d       = seed_q;
    load_d       = 1'b0;
    shift_d      = 1'b0;
    lockup_d     = lockup_q;
    go_load      = 1'b0;
    go_run_after = 1'b0;

    if (cap_pend_q) begin
      led_d = lfsr_q;
      if (lfsr_q == '0) begin
        lockup_d = 1'b1;
        force_d  = 1'b1;
      end
    end

    if (state_q == StLoad) begin
      state_d     = run_after_q ? StRun : StPause;
      run_after_d = 1'b0;
    end else if (!busy) begin
      if (force_q) begin
        // Recovery load keeps RUN/PAUSE and leaves button events pending.
        force_d     = 1'b0;
        state_d     = StLoad;
        load_d      = 1'b1;
        seed_d      = SAFE_SEED;
        run_after_d = (state_q == StRun);
      end else begin
        pend_load_d = 1'b0;
        pend_run_d  = 1'b0;
        pend_step_d = 1'b0;
        tick_pend_d = 1'b0;
        unique case (state_q)
          StIdle: begin
            if (ev_load) begin
              go_load = 1'b1;
            end else if (ev_run) begin
              go_load      = 1'b1;
              go_run_after = 1'b1;
            end
          end
          StRun: begin
            if (ev_load) begin
              go_load      = 1'b1;
              go_run_after = 1'b1;
            end else if (ev_run) begin
              state_d = StPause;
            end else if (ev_tick && !ev_step) begin
              if (cnt_q == CntMax) begin
                shift_d = 1'b1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CntW'(1);
              end
            end
          end
          StPause: begin
            if (ev_load) begin
              go_load = 1'b1;
            end else if (ev_run) begin
              state_d = StRun;
            end else if (ev_step) begin
              shift_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    if (go_load) begin
      state_d     = StLoad;
      load_d      = 1'b1;
      seed_d      = (seed_sw != '0) ? seed_sw : SAFE_SEED;
      lockup_d    = 1'b0;
      run_after_d = go_run_after;
    end

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      run_after_q <= 1'b0;
      cnt_q       <= '0;
      tick_pend_q <= 1'b0;
      pend_load_q <= 1'b0;
      pend_run_q  <= 1'b0;
      pend_step_q <= 1'b0;
      cap_pend_q  <= 1'b0;
      force_q     <= 1'b0;
      led_q       <= '0;
      seed_q      <= '0;
      load_q      <= 1'b0;
      shift_q     <= 1'b0;
      running_q   <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_after_q <= run_after_d;
      cnt_q       <= cnt_d;
      tick_pend_q <= tick_pend_d;
      pend_load_q <= pend_load_d;
      pend_run_q  <= pend_run_d;
      pend_step_q <= pend_step_d;
      cap_pend_q  <= cap_pend_d;
      force_q     <= force_d;
      led_q       <= led_d;
      seed_q      <= seed_d;
      load_q      <= load_d;
      shift_q     <= shift_d;
      running_q   <= running_d;
      lockup_q    <= lockup_d;
    end
  end

  assign lfsr_load  = load_q;
  assign lfsr_seed  = seed_q;
  assign lfsr_shift = shift_q;
  assign led        = led_q;
  assign running    = running_q;
  assign lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_led_sequencer.sv
// Randomized scenario bench for lfsr_led_sequencer with an external LFSR datapath model.
module tb_lfsr_led_sequencer;
  import lfsr_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned RDIV = 2;

  logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic        btn_run = 1'b0, btn_step = 1'b0, btn_load = 1'b0;
  logic [15:0] seed_sw = 16'h0, dp_q = 16'h0;
  logic        lfsr_load, lfsr_shift, running, lockup;
  logic [15:0] lfsr_seed, led;

  int total = 0, bad = 0;
  int n_load = 0, n_shift = 0, n_both = 0;
  bit force_zero = 1'b0;
  logic [15:0] exp_lfsr = 16'h0;  // what the LEDs must show once the latest command is captured
  int rem = 0;                    // ticks accepted in RUN since the last automatic shift

  lfsr_led_sequencer #(.DEBOUNCE_CYCLES(DEB), .RATE_DIV(RDIV), .SAFE_SEED(16'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_run(btn_run), .btn_step(btn_step),
    .btn_load(btn_load), .seed_sw(seed_sw), .lfsr_q(dp_q), .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed), .lfsr_shift(lfsr_shift), .led(led), .running(running),
    .lockup(lockup)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // External datapath: obeys the command pulses; force_zero models a corrupted step.
  always @(posedge clk) begin
    if (lfsr_load) dp_q <= lfsr_seed;
    else if (lfsr_shift) dp_q <= force_zero ? 16'h0 : lfsr_next(dp_q);
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (lfsr_load) n_load++;
      if (lfsr_shift) n_shift++;
      if (lfsr_load && lfsr_shift) n_both++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic press(input int which, input int hold);
    case (which)
      0: btn_load = 1'b1;
      1: btn_run = 1'b1;
      default: btn_step = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    btn_load = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic give_tick(input int gap);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    int s0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (led !== 16'h0) begin bad++; $display("FAIL reset_led: got %h want 0000", led); end
    total++; if (lfsr_seed !== 16'h0) begin bad++; $display("FAIL reset_seed: got %h want 0000", lfsr_seed); end
    total++; if ({lfsr_load, lfsr_shift} !== 2'b00) begin bad++; $display("FAIL reset_cmd: got %b want 00", {lfsr_load, lfsr_shift}); end
    total++; if ({running, lockup} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {running, lockup}); end
    total++; if (dut.state_q !== StIdle) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, StIdle); end
    rst_n = 1'b1;
    s0 = n_shift;
    give_tick(3);
    press(2, 8);
    total++; if (n_shift != s0 || dut.state_q !== StIdle) begin bad++; $display("FAIL idle_ignore: got shifts=%0d state=%0d want shifts=0 state=%0d", n_shift - s0, dut.state_q, StIdle); end
  endtask

  task automatic test_load();
    int lat = 0, l0;
    bit found = 0;
    l0 = n_load;
    seed_sw = 16'hACE1;
    @(negedge clk); btn_load = 1'b1;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (lfsr_load) begin found = 1; lat = i; end
    end
    total++; if (!found || lat < 6 || lat > 7) begin bad++; $display("FAIL load_latency: got %0d want 6..7", lat); end
    total++; if (lfsr_seed !== 16'hACE1) begin bad++; $display("FAIL load_seed: got %h want ace1", lfsr_seed); end
    @(negedge clk);
    total++; if (lfsr_load !== 1'b0) begin bad++; $display("FAIL load_width: got %b want 0", lfsr_load); end
    @(negedge clk);
    total++; if (led !== 16'hACE1) begin bad++; $display("FAIL load_led: got %h want ace1", led); end
    total++; if (dut.state_q !== StPause || running !== 1'b0) begin bad++; $display("FAIL load_pause: got state=%0d running=%b want state=%0d running=0", dut.state_q, running, StPause); end
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (n_load - l0 != 1) begin bad++; $display("FAIL load_once: got %0d want 1", n_load - l0); end
    exp_lfsr = 16'hACE1;
  endtask

  task automatic test_zero_seed();
    bit found = 0;
    int s0;
    seed_sw = 16'h0000;
    @(negedge clk); btn_load = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (lfsr_load) found = 1; end
    total++; if (!found || lfsr_seed !== 16'h0001) begin bad++; $display("FAIL zero_seed: got found=%0d seed=%h want found=1 seed=0001", found, lfsr_seed); end
    repeat (2) @(negedge clk);
    total++; if (led !== 16'h0001) begin bad++; $display("FAIL zero_led: got %h want 0001", led); end
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    force_zero = 1'b1;
    s0 = n_shift;
    found = 0;
    btn_step = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (lfsr_shift) found = 1; end
    @(negedge clk); force_zero = 1'b0;
    @(negedge clk);
    total++; if (!found || led !== 16'h0 || lockup !== 1'b1) begin bad++; $display("FAIL lockup_set: got found=%0d led=%h lockup=%b want found=1 led=0000 lockup=1", found, led, lockup); end
    @(negedge clk);
    total++; if (lfsr_load !== 1'b1 || lfsr_seed !== 16'h0001) begin bad++; $display("FAIL lockup_reload: got load=%b seed=%h want load=1 seed=0001", lfsr_load, lfsr_seed); end
    repeat (2) @(negedge clk);
    total++; if (led !== 16'h0001 || lockup !== 1'b1 || dut.state_q !== StPause) begin bad++; $display("FAIL lockup_recover: got led=%h lockup=%b state=%0d want led=0001 lockup=1 state=%0d", led, lockup, dut.state_q, StPause); end
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (n_shift - s0 != 1) begin bad++; $display("FAIL lockup_shifts: got %0d want 1", n_shift - s0); end
    exp_lfsr = 16'h0001;
  endtask

  task automatic test_run_ticks();
    int s0, exp_shifts = 0, n;
    press(1, 8);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_enter: got %b want 1", running); end
    s0 = n_shift;
    for (int i = 0; i < 6; i++) begin
      give_tick(4);
      rem++;
      if (rem == RDIV) begin rem = 0; exp_shifts++; exp_lfsr = lfsr_next(exp_lfsr); end
      total++; if (n_shift - s0 != exp_shifts) begin bad++; $display("FAIL tick_shift_%0d: got %0d want %0d", i, n_shift - s0, exp_shifts); end
      total++; if (led !== exp_lfsr) begin bad++; $display("FAIL tick_led_%0d: got %h want %h", i, led, exp_lfsr); end
    end
    n = $urandom_range(3, 9);
    for (int i = 0; i < n; i++) begin
      give_tick($urandom_range(4, 9));
      rem++;
      if (rem == RDIV) begin rem = 0; exp_shifts++; exp_lfsr = lfsr_next(exp_lfsr); end
    end
    total++; if (n_shift - s0 != exp_shifts) begin bad++; $display("FAIL rand_ticks: got %0d want %0d", n_shift - s0, exp_shifts); end
    total++; if (led !== exp_lfsr) begin bad++; $display("FAIL rand_led: got %h want %h", led, exp_lfsr); end
  endtask

  task automatic test_step_debounce();
    int s0;
    s0 = n_shift;
    press(2, 8);
    total++; if (n_shift != s0) begin bad++; $display("FAIL step_in_run: got %0d want 0", n_shift - s0); end
    press(1, 8);
    total++; if (running !== 1'b0 || dut.state_q !== StPause) begin bad++; $display("FAIL pause_enter: got running=%b state=%0d want running=0 state=%0d", running, dut.state_q, StPause); end
    s0 = n_shift;
    repeat ($urandom_range(3, 6)) begin
      btn_step = 1'b1; repeat ($urandom_range(1, 3)) @(negedge clk);
      btn_step = 1'b0; repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    btn_step = 1'b1;
    repeat (10) @(negedge clk);
    repeat ($urandom_range(2, 4)) begin
      btn_step = 1'b0; repeat ($urandom_range(1, 3)) @(negedge clk);
      btn_step = 1'b1; repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    exp_lfsr = lfsr_next(exp_lfsr);
    total++; if (n_shift - s0 != 1) begin bad++; $display("FAIL bounce_shifts: got %0d want 1", n_shift - s0); end
    total++; if (led !== exp_lfsr) begin bad++; $display("FAIL bounce_led: got %h want %h", led, exp_lfsr); end
  endtask

  task automatic test_back_to_back();
    bit found = 0, saw_pause = 0;
    int l0;
    logic [15:0] sd;
    press(1, 8);
    while (rem != RDIV - 1) begin give_tick(5); rem++; end
    sd = 16'($urandom_range(1, 65535));
    seed_sw = sd;
    l0 = n_load;
    @(negedge clk); btn_run = 1'b1; btn_load = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dut.state_q === StPause) saw_pause = 1;
      if (lfsr_load) found = 1;
    end
    total++; if (!found || lfsr_seed !== sd) begin bad++; $display("FAIL b2b_load: got found=%0d seed=%h want found=1 seed=%h", found, lfsr_seed, sd); end
    total++; if (lockup !== 1'b0) begin bad++; $display("FAIL b2b_lockup_clear: got %b want 0", lockup); end
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    total++; if (lfsr_shift !== 1'b0) begin bad++; $display("FAIL defer_early: got %b want 0", lfsr_shift); end
    @(negedge clk);
    total++; if (lfsr_shift !== 1'b1) begin bad++; $display("FAIL defer_late: got %b want 1", lfsr_shift); end
    rem = 0;
    exp_lfsr = lfsr_next(sd);
    repeat (2) @(negedge clk);
    total++; if (led !== exp_lfsr || running !== 1'b1) begin bad++; $display("FAIL b2b_led: got led=%h running=%b want led=%h running=1", led, running, exp_lfsr); end
    btn_run = 1'b0; btn_load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dut.state_q === StPause) saw_pause = 1;
    end
    total++; if (saw_pause || n_load - l0 != 1) begin bad++; $display("FAIL b2b_no_pause: got pause=%0d loads=%0d want pause=0 loads=1", saw_pause, n_load - l0); end
  endtask

  task automatic test_reset_mid_run();
    bit stale = 0;
    while (rem != RDIV - 1) begin give_tick(5); rem++; end
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    total++; if (lfsr_shift !== 1'b1) begin bad++; $display("FAIL mid_shift: got %b want 1", lfsr_shift); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({lfsr_load, lfsr_shift, running, lockup} !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags: got %b want 0000", {lfsr_load, lfsr_shift, running, lockup}); end
    total++; if (led !== 16'h0 || lfsr_seed !== 16'h0) begin bad++; $display("FAIL mid_rst_data: got led=%h seed=%h want 0000", led, lfsr_seed); end
    total++; if (dut.state_q !== StIdle) begin bad++; $display("FAIL mid_rst_state: got %0d want %0d", dut.state_q, StIdle); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (led !== 16'h0 || lfsr_load || lfsr_shift) stale = 1;
    end
    total++; if (stale) begin bad++; $display("FAIL stale_capture: got stale=1 want stale=0"); end
    total++; if (n_both != 0) begin bad++; $display("FAIL cmd_overlap: got %0d want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_zero_seed();
    test_run_ticks();
    test_step_debounce();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
